// File: rtl/vsamp_pkg.sv
// Shared state encoding and datapath widths for the voltage_sampler ADC front-end.
package vsamp_pkg;
  localparam int SAMPLE_W  = 12;
  localparam int AVG_SUM_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    WAIT
  } vsamp_state_t;
endpackage

// File: rtl/vsamp_avg4.sv
// Four-deep sample history with a truncating mean; the output follows the history registers,
// so it moves on the cycle after load, together with the parent's registered valid strobe.
module vsamp_avg4
  import vsamp_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] RESET_VALUE = 12'd2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] avg
);
  logic [SAMPLE_W-1:0]  hist [4];
  logic [AVG_SUM_W-1:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist[0] <= RESET_VALUE;
      hist[1] <= RESET_VALUE;
      hist[2] <= RESET_VALUE;
      hist[3] <= RESET_VALUE;
    end else if (load) begin
      hist[0] <= sample;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hist[3] <= hist[2];
    end
  end

  always_comb begin
    sum = AVG_SUM_W'(hist[0]) + AVG_SUM_W'(hist[1]) + AVG_SUM_W'(hist[2]) + AVG_SUM_W'(hist[3]);
  end

  assign avg = sum[AVG_SUM_W-1:2];
endmodule

// File: rtl/voltage_sampler.sv
// Periodic SPI (CPOL=0/CPHA=0) master for a 12-bit ADC; sample_valid 101 clk after cs_n falls at defaults.
// No backpressure: each sample is published and held. VSAMP_AVG4_EN selects a 4-sample moving average.
module voltage_sampler
  import vsamp_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_BITS   = SAMPLE_W,
  parameter int SAMPLE_PERIOD = 128,
  parameter int RESET_VALUE   = 2000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   adc_miso,
  output logic                   adc_sclk,
  output logic                   adc_cs_n,
  output logic [SAMPLE_BITS-1:0] voltage_out,
  output logic                   sample_valid,
  output logic                   busy
);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int HALF_W = $clog2(2 * SAMPLE_BITS + 1);
  localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * SAMPLE_BITS - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [PER_W-1:0]  PER_MAX   = PER_W'(SAMPLE_PERIOD);
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);

  vsamp_state_t           state;
  logic [DIV_W-1:0]       div_cnt;
  logic [HALF_W-1:0]      half_cnt;
  logic [PER_W-1:0]       period_cnt;
  logic [SAMPLE_BITS-1:0] shift_reg;
  logic                   publish;

  assign publish = (state == CS_HOLD) && (div_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      half_cnt     <= '0;
      period_cnt   <= '0;
      shift_reg    <= '0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (period_cnt < PER_MAX) period_cnt <= period_cnt + PER_ONE;
      case (state)
        IDLE: begin
          if (enable) begin
            state      <= CS_SETUP;
            div_cnt    <= '0;
            period_cnt <= PER_ONE;
            adc_cs_n   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        // CS_SETUP doubles as the low half before the first rising edge.
        CS_SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            half_cnt  <= '0;
            state     <= SHIFT;
            adc_sclk  <= 1'b1;
            shift_reg <= {shift_reg[SAMPLE_BITS-2:0], adc_miso};
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (half_cnt == HALF_LAST) begin
              state    <= CS_HOLD;
              adc_cs_n <= 1'b1;
              busy     <= 1'b0;
            end else begin
              half_cnt <= half_cnt + HALF_ONE;
              adc_sclk <= ~adc_sclk;
              if (!adc_sclk) shift_reg <= {shift_reg[SAMPLE_BITS-2:0], adc_miso};
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        CS_HOLD: begin
          if (div_cnt == '0) sample_valid <= 1'b1;
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (period_cnt < PER_MAX) begin
              state <= WAIT;
            end else if (enable) begin
              state      <= CS_SETUP;
              period_cnt <= PER_ONE;
              adc_cs_n   <= 1'b0;
              busy       <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        WAIT: begin
          if (period_cnt >= PER_MAX) begin
            if (enable) begin
              state      <= CS_SETUP;
              div_cnt    <= '0;
              period_cnt <= PER_ONE;
              adc_cs_n   <= 1'b0;
              busy       <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VSAMP_AVG4_EN
  vsamp_avg4 #(
    .RESET_VALUE(SAMPLE_W'(RESET_VALUE))
  ) u_avg4 (
    .clk   (clk),
    .reset (reset),
    .load  (publish),
    .sample(shift_reg),
    .avg   (voltage_out)
  );
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) voltage_out <= SAMPLE_BITS'(RESET_VALUE);
    else if (publish) voltage_out <= shift_reg;
  end
`endif
endmodule
